apm_osc_meas_ctrl: RTL and testbench

//  Digital sequencer/counter for the APM (analog process monitor) hard macro. Sweeps a channel mask over
//  the APM mux, enables the oscillator and counts its edges over a programmable reference window.

---
 rtl/apm_osc_meas_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_apm_osc_meas_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apm_osc_meas_ctrl.sv
// APM oscillator measurement sequencer: sweeps a channel mask, counts oscillator edges per window.
// Optional min/max result tracking is compiled in with APM_MINMAX_TRACK_EN.
module apm_osc_meas_ctrl #(
  parameter int N_CH       = 16,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [WIN_W-1:0] win_cycles,
  input  logic [1:0]       xtor_sel,
  input  logic [3:0]       vdac_sel,
  input  logic             apm_osc_in,
  output logic             apm_en_osc,
  output logic             apm_en_sensor,
  output logic [3:0]       apm_mux_sel,
  output logic [1:0]       apm_xtor_sel,
  output logic [3:0]       apm_vdac_sel,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_ch,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf,
  output logic             done
`ifdef APM_MINMAX_TRACK_EN
  ,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count,
  output logic [3:0]       min_ch,
  output logic [3:0]       max_ch
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // SETTLE | oscillator enabled, counter held at 0 for SETTLE_CYC cycles
  // MEAS   | counting synchronised oscillator edges for the window
  // HOLD   | result presented, waiting for res_ready
  // FIN    | one-cycle done pulse, back to IDLE

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] TMR_ONE  = 1;
  localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = 1;
  localparam logic [N_CH-1:0]  MASK_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEAS,
    S_HOLD,
    S_FIN
  } state_t;

  state_t state_q, state_nxt;

  logic [TMR_W-1:0] tmr_q;
  logic [WIN_W-1:0] win_q;
  logic [N_CH-1:0]  pend_q;
  logic [3:0]       ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             osc_s1_q, osc_s2_q, osc_s3_q;
  logic             en_osc_q, en_sensor_q;
  logic [1:0]       xtor_q;
  logic [3:0]       vdac_q;

  logic             tmr_tc;
  logic             start_ok;
  logic             accept;
  logic             enter_settle;
  logic             enter_meas;
  logic             osc_edge;
  logic [TMR_W-1:0] win_load;

  function automatic logic [3:0] low_idx(input logic [N_CH-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign tmr_tc       = (tmr_q == '0);
  assign start_ok     = (state_q == S_IDLE) && start;
  assign accept       = (state_q == S_HOLD) && res_ready;
  assign enter_settle = (state_q != S_SETTLE) && (state_nxt == S_SETTLE);
  assign enter_meas   = (state_q == S_SETTLE) && (state_nxt == S_MEAS);
  assign osc_edge     = osc_s2_q & ~osc_s3_q;
  // A zero window is stretched to one cycle.
  assign win_load     = (win_q == '0) ? '0 : TMR_W'(win_q - WIN_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_nxt = (ch_mask == '0) ? S_FIN : S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_tc) state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (tmr_tc) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) state_nxt = (pend_q != '0) ? S_SETTLE : S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencing datapath: configuration capture, channel walk, phase timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q       <= '0;
      win_q       <= '0;
      pend_q      <= '0;
      ch_q        <= '0;
      xtor_q      <= '0;
      vdac_q      <= '0;
      en_osc_q    <= 1'b0;
      en_sensor_q <= 1'b0;
    end else begin
      if (start_ok) begin
        win_q  <= win_cycles;
        xtor_q <= xtor_sel;
        vdac_q <= vdac_sel;
        ch_q   <= low_idx(ch_mask);
        pend_q <= ch_mask & (ch_mask - MASK_ONE);
      end else if (accept && (pend_q != '0)) begin
        ch_q   <= low_idx(pend_q);
        pend_q <= pend_q & (pend_q - MASK_ONE);
      end

      if (enter_settle)      tmr_q <= SET_LOAD;
      else if (enter_meas)   tmr_q <= win_load;
      else if (!tmr_tc)      tmr_q <= tmr_q - TMR_ONE;

      // Macro enables are registered so the analog pins never see decode glitches.
      en_osc_q    <= (state_nxt == S_SETTLE) || (state_nxt == S_MEAS);
      en_sensor_q <= (state_nxt == S_SETTLE) || (state_nxt == S_MEAS) ||
                     (state_nxt == S_HOLD);
    end
  end

  // Oscillator is asynchronous: two-flop synchroniser followed by an edge-detect flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osc_s1_q <= 1'b0;
      osc_s2_q <= 1'b0;
      osc_s3_q <= 1'b0;
    end else begin
      osc_s1_q <= apm_osc_in;
      osc_s2_q <= osc_s1_q;
      osc_s3_q <= osc_s2_q;
    end
  end

  // Only edges detected while in MEAS are counted; anything earlier in the pipe is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (enter_settle) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if ((state_q == S_MEAS) && osc_edge) begin
      if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
      else                  cnt_q <= cnt_q + CNT_ONE;
    end
  end

`ifdef APM_MINMAX_TRACK_EN
  logic seen_q;

  // Results arrive in ascending channel order, so strict compares keep the lower channel on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q    <= 1'b0;
      min_count <= '0;
      max_count <= '0;
      min_ch    <= '0;
      max_ch    <= '0;
    end else if (start_ok) begin
      seen_q    <= 1'b0;
      min_count <= '0;
      max_count <= '0;
      min_ch    <= '0;
      max_ch    <= '0;
    end else if (accept) begin
      seen_q <= 1'b1;
      if (!seen_q || (cnt_q < min_count)) begin
        min_count <= cnt_q;
        min_ch    <= ch_q;
      end
      if (!seen_q || (cnt_q > max_count)) begin
        max_count <= cnt_q;
        max_ch    <= ch_q;
      end
    end
  end
`endif

  assign apm_en_osc    = en_osc_q;
  assign apm_en_sensor = en_sensor_q;
  assign apm_mux_sel   = ch_q;
  assign apm_xtor_sel  = xtor_q;
  assign apm_vdac_sel  = vdac_q;
  assign busy          = (state_q == S_SETTLE) || (state_q == S_MEAS) || (state_q == S_HOLD);
  assign res_valid     = (state_q == S_HOLD);
  assign res_ch        = ch_q;
  assign res_count     = cnt_q;
  assign res_ovf       = ovf_q;
  assign done          = (state_q == S_FIN);

endmodule

// File: tb/tb_apm_osc_meas_ctrl.sv
// Directed bench for apm_osc_meas_ctrl: a default instance plus a 4-bit counter instance in lockstep.
// Min/max checks are included when APM_MINMAX_TRACK_EN is defined.
module tb_apm_osc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ch_mask = '0;
  logic [15:0] win_cycles = '0;
  logic [1:0]  xtor_sel = '0;
  logic [3:0]  vdac_sel = '0;
  logic        res_ready = 1'b0;
  logic        osc_a, osc_b, wave;

  logic        apm_en_osc, apm_en_sensor, busy, res_valid, res_ovf, done;
  logic [3:0]  apm_mux_sel, apm_vdac_sel, res_ch;
  logic [1:0]  apm_xtor_sel;
  logic [15:0] res_count;

  logic        f_en_osc, f_en_sensor, f_busy, f_res_valid, f_res_ovf, f_done;
  logic [3:0]  f_mux_sel, f_vdac_sel, f_res_ch;
  logic [1:0]  f_xtor_sel;
  logic [3:0]  f_res_count;

`ifdef APM_MINMAX_TRACK_EN
  logic [15:0] min_count, max_count;
  logic [3:0]  min_ch, max_ch;
  logic [3:0]  f_min_count, f_max_count, f_min_ch, f_max_ch;
`endif

  apm_osc_meas_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .win_cycles(win_cycles),
    .xtor_sel(xtor_sel), .vdac_sel(vdac_sel), .apm_osc_in(osc_a),
    .apm_en_osc(apm_en_osc), .apm_en_sensor(apm_en_sensor), .apm_mux_sel(apm_mux_sel),
    .apm_xtor_sel(apm_xtor_sel), .apm_vdac_sel(apm_vdac_sel), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_count(res_count),
    .res_ovf(res_ovf), .done(done)
`ifdef APM_MINMAX_TRACK_EN
    , .min_count(min_count), .max_count(max_count), .min_ch(min_ch), .max_ch(max_ch)
`endif
  );

  apm_osc_meas_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .win_cycles(win_cycles),
    .xtor_sel(xtor_sel), .vdac_sel(vdac_sel), .apm_osc_in(osc_b),
    .apm_en_osc(f_en_osc), .apm_en_sensor(f_en_sensor), .apm_mux_sel(f_mux_sel),
    .apm_xtor_sel(f_xtor_sel), .apm_vdac_sel(f_vdac_sel), .busy(f_busy),
    .res_valid(f_res_valid), .res_ready(res_ready), .res_ch(f_res_ch), .res_count(f_res_count),
    .res_ovf(f_res_ovf), .done(f_done)
`ifdef APM_MINMAX_TRACK_EN
    , .min_count(f_min_count), .max_count(f_max_count), .min_ch(f_min_ch), .max_ch(f_max_ch)
`endif
  );

  always #5 clk = ~clk;

  // Oscillator model: square wave whose period (in clk cycles) depends on the selected channel.
  int per_tab [16];
  int ph = 0;
  int per_cur;
  always @(negedge clk) ph <= ph + 1;
  assign per_cur = per_tab[apm_mux_sel];
  assign wave    = (ph % per_cur) < (per_cur / 2);
  assign osc_a   = wave & apm_en_osc;
  assign osc_b   = wave & f_en_osc;

  int q_ch [$];
  int q_cnt [$];
  int q_ovf [$];
  int q4_cnt [$];
  int q4_ovf [$];
  int done_cnt = 0;
  int rv_seen = 0;

  always @(posedge clk) begin
    if (res_valid && res_ready) begin
      q_ch.push_back(int'(res_ch));
      q_cnt.push_back(int'(res_count));
      q_ovf.push_back(int'(res_ovf));
    end
    if (f_res_valid && res_ready) begin
      q4_cnt.push_back(int'(f_res_count));
      q4_ovf.push_back(int'(f_res_ovf));
    end
    if (done) done_cnt = done_cnt + 1;
    if (res_valid) rv_seen = 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_ch.delete(); q_cnt.delete(); q_ovf.delete();
    q4_cnt.delete(); q4_ovf.delete();
    done_cnt = 0;
    rv_seen  = 0;
  endtask

  task automatic do_start(input logic [15:0] mask, input logic [15:0] win);
    ch_mask    = mask;
    win_cycles = win;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check_val(tag, done, 1);
  endtask

  initial begin
    int n;
    int bad;
    for (int i = 0; i < 16; i++) per_tab[i] = 4;

    // Reset state
    repeat (3) tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_valid", res_valid, 0);
    check_val("rst_en_osc", apm_en_osc, 0);
    check_val("rst_en_sensor", apm_en_sensor, 0);
    check_val("rst_mux", apm_mux_sel, 0);
    check_val("rst_count", res_count, 0);
    rst = 1'b0;
    tick();

    // Empty mask: done at T+1, nothing else
    clear_log();
    res_ready = 1'b1;
    do_start(16'h0000, 16'd10);
    check_val("t2_done", done, 1);
    check_val("t2_busy", busy, 0);
    tick();
    check_val("t2_done_low", done, 0);
    repeat (5) tick();
    check_val("t2_busy_after", busy, 0);
    check_val("t2_no_valid", rv_seen, 0);
    check_val("t2_done_cnt", done_cnt, 1);

    // Two channels, free-running consumer; 4-bit instance saturates
    clear_log();
    xtor_sel = 2'd2;
    vdac_sel = 4'd9;
    do_start(16'h0005, 16'd100);
    check_val("t3_busy", busy, 1);
    check_val("t3_en_sensor", apm_en_sensor, 1);
    check_val("t3_en_osc", apm_en_osc, 1);
    check_val("t3_mux_first", apm_mux_sel, 0);
    check_val("t3_xtor", apm_xtor_sel, 2);
    check_val("t3_vdac", apm_vdac_sel, 9);
    wait_done(400, "t3_done_seen");
    tick();
    check_val("t3_nres", q_ch.size(), 2);
    check_val("t3_ch0", q_ch[0], 0);
    check_val("t3_ch1", q_ch[1], 2);
    check_val("t3_cnt0", q_cnt[0], 25);
    check_val("t3_cnt1", q_cnt[1], 25);
    check_val("t3_ovf0", q_ovf[0], 0);
    check_val("t3_ovf1", q_ovf[1], 0);
    check_val("t3_done_cnt", done_cnt, 1);
    check_val("t3_busy_end", busy, 0);
    check_val("t4_nres", q4_cnt.size(), 2);
    check_val("t4_cnt0", q4_cnt[0], 15);
    check_val("t4_ovf0", q4_ovf[0], 1);
    check_val("t4_cnt1", q4_cnt[1], 15);
    check_val("t4_ovf1", q4_ovf[1], 1);

    // Consumer stall on first result
    clear_log();
    res_ready = 1'b0;
    do_start(16'h8001, 16'd20);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_val("t5_valid", res_valid, 1);
    check_val("t5_count", res_count, 5);
    bad = 0;
    repeat (50) begin
      tick();
      if (res_valid !== 1'b1 || res_ch !== 4'd0 || res_count !== 16'd5 ||
          apm_en_osc !== 1'b0 || apm_mux_sel !== 4'd0 || busy !== 1'b1) bad++;
    end
    check_val("t5_stall_stable", bad, 0);
    res_ready = 1'b1;
    tick();
    check_val("t5_mux_next", apm_mux_sel, 15);
    check_val("t5_en_osc_next", apm_en_osc, 1);
    check_val("t5_valid_drop", res_valid, 0);
    wait_done(200, "t5_done_seen");
    tick();
    check_val("t5_nres", q_ch.size(), 2);
    check_val("t5_ch0", q_ch[0], 0);
    check_val("t5_ch1", q_ch[1], 15);
    check_val("t5_cnt1", q_cnt[1], 5);

    // Reset during MEAS on channel 3
    clear_log();
    do_start(16'h0008, 16'd100);
    repeat (12) tick();
    check_val("t1_pre_busy", busy, 1);
    check_val("t1_pre_mux", apm_mux_sel, 3);
    #2 rst = 1'b1;
    #1;
    check_val("t1_busy", busy, 0);
    check_val("t1_en_osc", apm_en_osc, 0);
    check_val("t1_en_sensor", apm_en_sensor, 0);
    check_val("t1_mux", apm_mux_sel, 0);
    check_val("t1_valid", res_valid, 0);
    check_val("t1_done", done, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    check_val("t1_no_done", done_cnt, 0);
    do_start(16'h0002, 16'd8);
    wait_done(100, "t1_restart_done");
    tick();
    check_val("t1_restart_nres", q_ch.size(), 1);
    check_val("t1_restart_ch", q_ch[0], 1);
    check_val("t1_restart_cnt", q_cnt[0], 2);

`ifdef APM_MINMAX_TRACK_EN
    // Min/max tracking with a tie on the maximum
    clear_log();
    per_tab[1] = 4;
    per_tab[2] = 8;
    per_tab[3] = 4;
    do_start(16'h000E, 16'd64);
    wait_done(400, "t6_done_seen");
    check_val("t6_min", min_count, 8);
    check_val("t6_max", max_count, 16);
    check_val("t6_min_ch", min_ch, 2);
    check_val("t6_max_ch", max_ch, 1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
